// File: rtl/mips_ex_stage.sv
// mips_ex_stage: MIPS-32 execute stage with EX/MEM latch, squash and HALT.
// Define MIPS_EX_SEQ_MUL_EN to run MUL on an iterative shift-add multiplier.
module mips_ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        id_ex_valid,
  input  logic [31:0] id_ex_ir,
  input  logic [31:0] id_ex_npc,
  input  logic [31:0] id_ex_a,
  input  logic [31:0] id_ex_b,
  input  logic [31:0] id_ex_imm,
  input  logic [2:0]  id_ex_type,
  output logic        ex_ready,
  output logic        ex_mem_valid,
  output logic [31:0] ex_mem_ir,
  output logic [31:0] ex_mem_aluout,
  output logic [31:0] ex_mem_b,
  output logic [2:0]  ex_mem_type,
  output logic        ex_mem_cond,
  output logic        taken_branch,
  output logic        halted
);
  localparam logic [2:0] RR_ALU = 3'd0;
  localparam logic [2:0] RM_ALU = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] STORE  = 3'd3;
  localparam logic [2:0] BRANCH = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
`ifndef MIPS_EX_SEQ_MUL_EN
  localparam logic [5:0] OP_MUL   = 6'h05;
`endif

  logic [5:0]  op;
  logic [31:0] opnd;
  logic [31:0] alu_res;
  logic [31:0] res;
  logic        br_cond;
  logic        accept;
  logic        live;
  logic        take;
  logic [1:0]  squash;

  assign op     = id_ex_ir[31:26];
  assign opnd   = (id_ex_type == RR_ALU) ? id_ex_b : id_ex_imm;
  assign accept = id_ex_valid && ex_ready && !halted;
  assign live   = (squash == 2'd0);
  assign take   = accept && live && (id_ex_type == BRANCH) &&
                  (((op == OP_BEQZ) && br_cond) ||
                   ((op == OP_BNEQZ) && !br_cond));

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD, OP_ADDI: alu_res = id_ex_a + opnd;
      OP_SUB, OP_SUBI: alu_res = id_ex_a - opnd;
      OP_AND:          alu_res = id_ex_a & opnd;
      OP_OR:           alu_res = id_ex_a | opnd;
      OP_SLT, OP_SLTI:
        alu_res = {31'd0, $signed(id_ex_a) < $signed(opnd)};
`ifndef MIPS_EX_SEQ_MUL_EN
      OP_MUL:          alu_res = id_ex_a * opnd;
`endif
      default:         alu_res = '0;
    endcase
  end

  always_comb begin
    res     = '0;
    br_cond = 1'b0;
    unique case (1'b1)
      (id_ex_type == RR_ALU) || (id_ex_type == RM_ALU):
        res = alu_res;
      (id_ex_type == LOAD) || (id_ex_type == STORE):
        res = id_ex_a + id_ex_imm;
      (id_ex_type == BRANCH): begin
        res     = id_ex_npc + id_ex_imm;
        br_cond = (id_ex_a == 32'd0);
      end
      default: res = '0;
    endcase
  end

`ifdef MIPS_EX_SEQ_MUL_EN
  // Each step retires BPS multiplier bits so any MUL_CYCLES covers 32 bits.
  localparam int BPS = (32 + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam logic [5:0] LAST = 6'(MUL_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] m_ir;
  logic [31:0] m_b;
  logic [2:0]  m_type;
  logic        is_mul;

  assign is_mul = ((id_ex_type == RR_ALU) ||
                   (id_ex_type == RM_ALU)) && (op == 6'h05);
  assign ex_ready = !halted && (state == IDLE);

  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < BPS; j++)
      if (mplier[j]) acc_nxt = acc_nxt + (mcand << j);
  end
`else
  assign ex_ready = !halted;
`endif

  always_ff @(posedge clk1) begin
    if (rst) begin
      ex_mem_valid  <= 1'b0;
      ex_mem_ir     <= '0;
      ex_mem_aluout <= '0;
      ex_mem_b      <= '0;
      ex_mem_type   <= '0;
      ex_mem_cond   <= 1'b0;
      taken_branch  <= 1'b0;
      halted        <= 1'b0;
      squash        <= 2'd0;
`ifdef MIPS_EX_SEQ_MUL_EN
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      m_ir   <= '0;
      m_b    <= '0;
      m_type <= '0;
`endif
    end else if (!halted) begin
      ex_mem_valid <= 1'b0;
      taken_branch <= 1'b0;
`ifdef MIPS_EX_SEQ_MUL_EN
      if (state == BUSY) begin
        acc    <= acc_nxt;
        mcand  <= mcand << BPS;
        mplier <= mplier >> BPS;
        cnt    <= cnt + 6'd1;
        if (cnt == LAST) begin
          state         <= IDLE;
          ex_mem_valid  <= 1'b1;
          ex_mem_ir     <= m_ir;
          ex_mem_aluout <= acc_nxt;
          ex_mem_b      <= m_b;
          ex_mem_type   <= m_type;
          ex_mem_cond   <= 1'b0;
        end
      end
`endif
      if (accept) begin
        if (take)
          squash <= 2'd2;
        else if (!live)
          squash <= squash - 2'd1;
`ifdef MIPS_EX_SEQ_MUL_EN
        if (live && is_mul) begin
          state  <= BUSY;
          cnt    <= '0;
          acc    <= '0;
          mcand  <= id_ex_a;
          mplier <= opnd;
          m_ir   <= id_ex_ir;
          m_b    <= id_ex_b;
          m_type <= id_ex_type;
        end else
`endif
        begin
          ex_mem_valid  <= live;
          ex_mem_ir     <= id_ex_ir;
          ex_mem_aluout <= res;
          ex_mem_b      <= id_ex_b;
          ex_mem_type   <= id_ex_type;
          ex_mem_cond   <= br_cond;
          taken_branch  <= take;
          halted        <= live && (id_ex_type == HALT);
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_ex_stage.sv
// tb_mips_ex_stage: scoreboard bench for the MIPS-32 execute stage.
// Expected MUL latency follows MIPS_EX_SEQ_MUL_EN.
module tb_mips_ex_stage;
`ifdef MIPS_EX_SEQ_MUL_EN
  localparam int MUL_LAT = 32;
`else
  localparam int MUL_LAT = 0;
`endif

  logic        clk1;
  logic        rst;
  logic        id_ex_valid;
  logic [31:0] id_ex_ir;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_a;
  logic [31:0] id_ex_b;
  logic [31:0] id_ex_imm;
  logic [2:0]  id_ex_type;
  logic        ex_ready;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_ir;
  logic [31:0] ex_mem_aluout;
  logic [31:0] ex_mem_b;
  logic [2:0]  ex_mem_type;
  logic        ex_mem_cond;
  logic        taken_branch;
  logic        halted;

  mips_ex_stage #(.MUL_CYCLES(32)) dut (
    .clk1          (clk1),
    .rst           (rst),
    .id_ex_valid   (id_ex_valid),
    .id_ex_ir      (id_ex_ir),
    .id_ex_npc     (id_ex_npc),
    .id_ex_a       (id_ex_a),
    .id_ex_b       (id_ex_b),
    .id_ex_imm     (id_ex_imm),
    .id_ex_type    (id_ex_type),
    .ex_ready      (ex_ready),
    .ex_mem_valid  (ex_mem_valid),
    .ex_mem_ir     (ex_mem_ir),
    .ex_mem_aluout (ex_mem_aluout),
    .ex_mem_b      (ex_mem_b),
    .ex_mem_type   (ex_mem_type),
    .ex_mem_cond   (ex_mem_cond),
    .taken_branch  (taken_branch),
    .halted        (halted)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] b;
    logic [2:0]  ty;
    logic        cond;
    logic        take;
    logic        chk_alu;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  bit   prev_h = 0;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ir, npc, a, b, imm,
                                 input logic [2:0] ty);
    exp_t e;
    logic [31:0] o;
    logic [5:0] op;
    op = ir[31:26];
    o = (ty == 3'd0) ? b : imm;
    e.ir = ir; e.b = b; e.ty = ty;
    e.alu = 32'd0; e.cond = 1'b0; e.take = 1'b0; e.chk_alu = 1'b1;
    case (ty)
      3'd0, 3'd1:
        case (op)
          6'h00, 6'h0A: e.alu = a + o;
          6'h01, 6'h0B: e.alu = a - o;
          6'h02: e.alu = a & o;
          6'h03: e.alu = a | o;
          6'h04, 6'h0C: e.alu = ($signed(a) < $signed(o)) ? 32'd1 : 32'd0;
          6'h05: e.alu = a * o;
          default: e.alu = 32'd0;
        endcase
      3'd2, 3'd3: e.alu = a + imm;
      3'd4: begin
        e.alu = npc + imm;
        e.cond = (a == 32'd0);
        e.take = (op == 6'h0E && e.cond) || (op == 6'h0D && !e.cond);
      end
      default: e.chk_alu = 1'b0;
    endcase
    return e;
  endfunction

  always @(negedge clk1) begin
    if (ex_mem_valid && !prev_h) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        me = sbq.pop_front();
        chk("ir", ex_mem_ir, me.ir);
        if (me.chk_alu) chk("aluout", ex_mem_aluout, me.alu);
        chk("b", ex_mem_b, me.b);
        chk("type", 32'(ex_mem_type), 32'(me.ty));
        if (me.ty == 3'd4) chk("cond", 32'(ex_mem_cond), 32'(me.cond));
        chk("taken", 32'(taken_branch), 32'(me.take));
      end
    end
    prev_h = halted;
  end

  task automatic drive(input logic [31:0] ir, npc, a, b, imm,
                       input logic [2:0] ty);
    id_ex_valid = 1'b1;
    id_ex_ir = ir; id_ex_npc = npc; id_ex_a = a;
    id_ex_b = b; id_ex_imm = imm; id_ex_type = ty;
  endtask

  task automatic issue(input logic [31:0] ir, npc, a, b, imm,
                       input logic [2:0] ty, input bit live);
    bit acc;
    drive(ir, npc, a, b, imm, ty);
    if (live) sbq.push_back(model(ir, npc, a, b, imm, ty));
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = ex_ready;
      @(posedge clk1); #1;
    end
    chk("accept", 32'(acc), 32'd1);
    id_ex_valid = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  logic [5:0]  ops [9];
  logic [31:0] ra, rb, ri, rr;
  logic [5:0]  rop;
  int          low;
  int          seen;

  initial begin
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0C};
    rst = 1'b1;
    id_ex_valid = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    id_ex_valid = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_valid", 32'(ex_mem_valid), 32'd0);
    chk("rst_alu", ex_mem_aluout, 32'd0);
    chk("rst_ir", ex_mem_ir, 32'd0);
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_taken", 32'(taken_branch), 32'd0);
    rst = 1'b0;
    @(posedge clk1); #1;

    issue(mk(6'h00), 32'h1, 32'hFFFFFFFF, 32'd2, 32'd0, 3'd0, 1);
    chk("add_lat_valid", 32'(ex_mem_valid), 32'd1);
    chk("add_lat_alu", ex_mem_aluout, 32'd1);
    issue(mk(6'h04), 32'h2, 32'hFFFFFFFE, 32'd1, 32'd0, 3'd0, 1);
    issue(mk(6'h0C), 32'h3, 32'd5, 32'd0, 32'hFFFFFFFF, 3'd1, 1);
    issue(mk(6'h01), 32'h4, 32'd3, 32'd5, 32'd0, 3'd0, 1);
    issue(mk(6'h02), 32'h5, 32'hF0F0, 32'hFF00, 32'd0, 3'd0, 1);
    issue(mk(6'h03), 32'h6, 32'hF0F0, 32'h0F0F, 32'd0, 3'd0, 1);
    issue(mk(6'h0B), 32'h7, 32'd1, 32'd9, 32'd2, 3'd1, 1);
    issue(mk(6'h08), 32'h8, 32'h100, 32'h55, 32'hFFFFFFFC, 3'd2, 1);
    issue(mk(6'h09), 32'h9, 32'h200, 32'hABCD, 32'd8, 3'd3, 1);
    issue(mk(6'h20), 32'hA, 32'd7, 32'd9, 32'd0, 3'd0, 1);
    @(posedge clk1); #1;
    chk("idle_valid", 32'(ex_mem_valid), 32'd0);

    // Taken BEQZ, two squashed ADDs, then a live ADD.
    issue(mk(6'h0E), 32'h10, 32'd0, 32'd0, 32'd4, 3'd4, 1);
    chk("beqz_taken", 32'(taken_branch), 32'd1);
    chk("beqz_alu", ex_mem_aluout, 32'h14);
    chk("beqz_cond", 32'(ex_mem_cond), 32'd1);
    issue(mk(6'h00), 32'h11, 32'd1, 32'd1, 32'd0, 3'd0, 0);
    chk("sq1_taken", 32'(taken_branch), 32'd0);
    chk("sq1_valid", 32'(ex_mem_valid), 32'd0);
    issue(mk(6'h00), 32'h12, 32'd2, 32'd2, 32'd0, 3'd0, 0);
    chk("sq2_valid", 32'(ex_mem_valid), 32'd0);
    issue(mk(6'h00), 32'h13, 32'd3, 32'd3, 32'd0, 3'd0, 1);
    chk("post_sq_valid", 32'(ex_mem_valid), 32'd1);

    // Taken BNEQZ; a squashed BEQZ must not branch or re-arm squash.
    issue(mk(6'h0D), 32'h20, 32'd5, 32'd0, 32'hFFFFFFF0, 3'd4, 1);
    chk("bneqz_taken", 32'(taken_branch), 32'd1);
    issue(mk(6'h00), 32'h21, 32'd1, 32'd1, 32'd0, 3'd0, 0);
    issue(mk(6'h0E), 32'h22, 32'd0, 32'd0, 32'd4, 3'd4, 0);
    chk("sq_br_taken", 32'(taken_branch), 32'd0);
    issue(mk(6'h00), 32'h23, 32'd4, 32'd4, 32'd0, 3'd0, 1);
    issue(mk(6'h0E), 32'h24, 32'd3, 32'd0, 32'd4, 3'd4, 1);
    chk("nt_taken", 32'(taken_branch), 32'd0);
    issue(mk(6'h00), 32'h25, 32'd5, 32'd5, 32'd0, 3'd0, 1);

    for (int i = 0; i < 24; i++) begin
      rop = ops[$urandom_range(0, 8)];
      ra = $urandom; rb = $urandom; rr = $urandom;
      if (i % 4 == 0) rb = ra;
      ri = {{16{rr[15]}}, rr[15:0]};
      issue({rop, 26'($urandom)}, 32'(i), ra, rb, ri,
            (rop <= 6'h05) ? 3'd0 : 3'd1, 1);
    end

    // Directed MUL with a decode-held ADD behind it.
    issue(mk(6'h00), 32'h30, 32'd7, 32'd8, 32'd0, 3'd0, 1);
    drive(mk(6'h05), 32'h31, 32'h10000, 32'h10003, 32'd0, 3'd0);
    sbq.push_back(model(mk(6'h05), 32'h31, 32'h10000, 32'h10003,
                        32'd0, 3'd0));
    chk("mul_start_ready", 32'(ex_ready), 32'd1);
    @(posedge clk1); #1;
    drive(mk(6'h00), 32'h32, 32'd20, 32'd22, 32'd0, 3'd0);
    sbq.push_back(model(mk(6'h00), 32'h32, 32'd20, 32'd22,
                        32'd0, 3'd0));
    low = 0;
    while (!ex_ready && low < 100) begin
      if (low == 5) begin
        chk("busy_valid", 32'(ex_mem_valid), 32'd0);
        chk("busy_hold", ex_mem_aluout, 32'd15);
      end
      @(posedge clk1); #1;
      low++;
    end
    chk("mul_lat", 32'(low), 32'(MUL_LAT));
    chk("mul_valid", 32'(ex_mem_valid), 32'd1);
    chk("mul_alu", ex_mem_aluout, 32'h00030000);
    @(posedge clk1); #1;
    id_ex_valid = 1'b0;
    chk("held_add_alu", ex_mem_aluout, 32'd42);

    // Reset ten counts into a MUL: nothing may emerge afterwards.
    drive(mk(6'h05), 32'h40, 32'd3, 32'd5, 32'd0, 3'd0);
`ifndef MIPS_EX_SEQ_MUL_EN
    sbq.push_back(model(mk(6'h05), 32'h40, 32'd3, 32'd5, 32'd0, 3'd0));
`endif
    @(posedge clk1); #1;
    id_ex_valid = 1'b0;
    repeat (10) @(posedge clk1);
    #1;
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    chk("mrst_valid", 32'(ex_mem_valid), 32'd0);
    chk("mrst_alu", ex_mem_aluout, 32'd0);
    chk("mrst_ready", 32'(ex_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk1); #1;
      if (ex_mem_valid) seen++;
    end
    chk("mrst_no_result", 32'(seen), 32'd0);

    // HALT then held ADDs: everything frozen until reset.
    issue(32'hFC000000, 32'h50, 32'd1, 32'h77, 32'd0, 3'd5, 1);
    chk("halted_set", 32'(halted), 32'd1);
    drive(mk(6'h00), 32'h51, 32'd1, 32'd1, 32'd0, 3'd0);
    repeat (5) @(posedge clk1);
    #1;
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_ready", 32'(ex_ready), 32'd0);
    chk("halt_valid", 32'(ex_mem_valid), 32'd1);
    chk("halt_ir", ex_mem_ir, 32'hFC000000);
    chk("halt_b", ex_mem_b, 32'h77);
    chk("halt_type", 32'(ex_mem_type), 32'd5);
    id_ex_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_ready", 32'(ex_ready), 32'd1);
    issue(mk(6'h00), 32'h60, 32'd100, 32'd23, 32'd0, 3'd0, 1);
    chk("hrst_add", ex_mem_aluout, 32'd123);
    @(posedge clk1); #1;

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
